// File: rtl/imem_boot_ctrl_if.sv
// Host loader stream between the program source and the instruction-memory boot controller.
// The master drives words; the slave (controller) answers with ld_ready.
interface imem_boot_ctrl_if #(
    parameter int data_size = 32
);
    logic                 ld_valid;
    logic [data_size-1:0] ld_data;
    logic                 ld_last;
    logic                 ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Owns the single-ported instruction memory: fills it from the host loader stream,
// then hands the read port to the CPU fetch path once the final word has been written.
module imem_boot_ctrl #(
    parameter int data_size    = 32,
    parameter int address_size = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_start,
    imem_boot_ctrl_if.slave        ld,
    input  logic [31:0]            cpu_pc,
    output logic [data_size-1:0]   cpu_instr,
    output logic                   cpu_stall,
    output logic [31:0]            mem_address,
    output logic [data_size-1:0]   mem_data_in,
    output logic                   mem_write,
    input  logic [data_size-1:0]   mem_data_out,
    output logic                   load_done,
    output logic                   load_error,
    output logic [address_size:0]  word_count
);

    localparam int memory_depth = 2 ** address_size;
    localparam logic [address_size-1:0] last_slot  = address_size'(memory_depth - 1);
    localparam logic [address_size:0]   full_count = (address_size + 1)'(memory_depth);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        ERROR
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [address_size-1:0] wr_ptr;
    logic                    handshake;
    logic                    ld_ready;
    logic [31:0]             load_address;

    assign load_address = 32'({wr_ptr, 2'b00});
    assign ld.ld_ready  = ld_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The pointer stops at the last slot instead of wrapping, so an overflowing
    // stream can never overwrite word 0; the count saturates one step later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
        end else begin
            load_done <= handshake & ld.ld_last;
            if (load_start) begin
                wr_ptr     <= '0;
                word_count <= '0;
            end else if (handshake) begin
                if (wr_ptr != last_slot) begin
                    wr_ptr <= wr_ptr + address_size'(1);
                end
                if (word_count != full_count) begin
                    word_count <= word_count + (address_size + 1)'(1);
                end
            end
        end
    end

    // ld_ready is qualified with rst_n so a reset cycle never commits a memory write.
    always_comb begin
        next_state  = state;
        ld_ready    = 1'b0;
        handshake   = 1'b0;
        cpu_stall   = 1'b1;
        cpu_instr   = '0;
        mem_address = load_address;
        mem_data_in = ld.ld_data;
        mem_write   = 1'b0;
        load_error  = 1'b0;

        case (state)
            IDLE: begin
                if (load_start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                ld_ready  = ~load_start & rst_n;
                handshake = ld_ready & ld.ld_valid;
                mem_write = handshake;
                if (load_start) begin
                    next_state = LOAD;
                end else if (handshake && ld.ld_last) begin
                    next_state = RUN;
                end else if (handshake && (wr_ptr == last_slot)) begin
                    next_state = ERROR;
                end
            end
            RUN: begin
                cpu_stall   = 1'b0;
                mem_address = cpu_pc;
                cpu_instr   = mem_data_out;
                if (load_start) begin
                    next_state = LOAD;
                end
            end
            ERROR: begin
                load_error = 1'b1;
                if (load_start) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/load controller that owns the single-ported instruction memory (32-bit words, word-addressed by byte address bits [address_size+1:2]) and shares it between a host loader stream and the CPU fetch port. After reset, and whenever a load is requested, it holds the CPU stalled and writes incoming words sequentially from address 0. On the last word it hands the memory to the CPU fetch path. It sits between the host interface, the CPU PC/fetch logic and the instruction memory.

## Interface
- data_size, 32, instruction word width
- address_size, 5, memory word-address bits; memory_depth = 2**address_size (derived, not set by user)

- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- load_start  in  1  request (re)load of program, sampled each cycle
- ld_valid  in  1  host word valid
- ld_data  in  data_size  host word
- ld_last  in  1  qualifies ld_data as final program word
- ld_ready  out  1  controller accepts word this cycle
- cpu_pc  in  32  CPU fetch byte address
- cpu_instr  out  data_size  fetched instruction to CPU
- cpu_stall  out  1  CPU must hold PC and not retire
- mem_address  out  32  to memory address
- mem_data_in  out  data_size  to memory write data
- mem_write  out  1  to memory write enable
- mem_data_out  in  data_size  from memory read data (combinational)
- load_done  out  1  one-cycle pulse, program loaded
- load_error  out  1  overflow flag, sticky until next load_start
- word_count  out  address_size+1  words written by last/current load

## Operation
- States: IDLE, LOAD, RUN, ERROR (registered). Reset → IDLE.
- IDLE: cpu_stall=1, ld_ready=0. load_start → LOAD.
- LOAD: ld_ready = ~load_start. Handshake = ld_valid & ld_ready. mem_write = handshake; mem_address = {wr_ptr, 2'b00} zero-extended to 32; mem_data_in = ld_data. On handshake wr_ptr and word_count increment.
  - handshake & ld_last → RUN; load_done=1 in the following cycle.
  - handshake & ~ld_last & wr_ptr == memory_depth-1 → ERROR (last slot written, no room left).
  - load_start in LOAD → restart: wr_ptr=0, word_count=0, stay LOAD; no write that cycle.
- RUN: cpu_stall=0, ld_ready=0, mem_write=0, mem_address=cpu_pc, cpu_instr=mem_data_out. load_start → LOAD (reload, wr_ptr=0, word_count=0).
- ERROR: cpu_stall=1, ld_ready=0, load_error=1. load_start → LOAD, clears load_error.
- Outside RUN: cpu_instr = 0 (NOP); mem_address = load address.
- wr_ptr is address_size bits, never wraps: overflow goes to ERROR, not back to 0.
- word_count saturates at memory_depth; holds value in RUN/ERROR.
- Memory contents are never cleared by reset or reload.

## Timing
- Reset values: state IDLE, wr_ptr 0, word_count 0, cpu_stall 1, ld_ready 0, mem_write 0, load_done 0, load_error 0, cpu_instr 0, mem_address 0.
- Reset mid-LOAD: next cycle IDLE, no further writes; already-written words remain.
- State transitions take effect the cycle after the triggering condition; load_start to first ld_ready = 1 cycle.
- ld_ready, mem_write, mem_address and mem_data_in are combinational from state, wr_ptr and inputs; the write occurs on the same posedge as the handshake.
- Throughput 1 word/cycle.
- First RUN cycle: cpu_stall=0 and load_done=1 simultaneously; CPU fetch of cpu_pc is valid in that cycle (zero-latency memory read).
- load_start and ld_valid&ld_last in the same LOAD cycle: load_start wins, word is not accepted, pointer resets.

## Test plan
- Reset, then load_start, stream 3 words 0xA,0xB,0xC (last on 0xC), no stalls → writes to 0x0,0x4,0x8; load_done pulses once; word_count=3; RUN with cpu_pc=0x4 → cpu_instr=0xB.
- ld_valid toggles 1,0,1,0 during LOAD → only cycles with ld_valid high write; addresses stay contiguous.
- Stream 32 words, none marked last (address_size=5) → 32 writes, then ERROR: load_error=1, cpu_stall=1, ld_ready=0, word_count=32; load_start clears error and re-enters LOAD.
- In RUN, assert load_start → cpu_stall=1 next cycle; reload of 2 words overwrites addresses 0,4 only; word 2 retains the old value.
- rst_n low for 1 cycle after 2 of 4 words → IDLE, all outputs at reset values, no write on reset cycle; next load restarts at address 0.
- load_start coincident with ld_valid&ld_last → no write, no load_done, wr_ptr=0.
